// File: rtl/lrf_frame_sink.sv
// AXI-Stream frame sink: writes LRF output frames into a ring of memory slots and checks frame length against tlast.
// Optional per-frame pixel checksum is built only when LRF_SINK_CHECKSUM_EN is defined.
module lrf_frame_sink #(
    parameter  int unsigned PIXELS_PER_BEAT = 16,
    parameter  int unsigned PIXEL_WIDTH     = 8,
    parameter  int unsigned IMAGE_DIM       = 512,
    parameter  int unsigned N_SLOTS         = 4,
    localparam int unsigned WORD_WIDTH      = PIXELS_PER_BEAT * PIXEL_WIDTH,
    localparam int unsigned WORDS_PER_IMAGE = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT,
    localparam int unsigned ADDR_WIDTH      = $clog2(N_SLOTS * WORDS_PER_IMAGE),
    localparam int unsigned SLOT_WIDTH      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  mem_wr_valid,
    input  logic                  mem_wr_ready,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    input  logic                  enable,
    input  logic                  err_clear,
    output logic                  frame_done,
    output logic [SLOT_WIDTH-1:0] frame_slot,
    output logic [31:0]           frame_count,
    output logic                  err_short,
    output logic                  err_long,
    output logic [31:0]           frame_checksum
);

    localparam int unsigned BEAT_WIDTH = (WORDS_PER_IMAGE > 1) ? $clog2(WORDS_PER_IMAGE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [BEAT_WIDTH-1:0] beat_cnt;
    logic [SLOT_WIDTH-1:0] slot;
    logic                  accept_c;
    logic                  last_beat_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [SLOT_WIDTH-1:0] next_slot_c;

    // Ready is combinational so a draining write stage can take a new beat in the same cycle.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_RECV:  s_axis_tready = !mem_wr_valid || mem_wr_ready;
            ST_DRAIN: s_axis_tready = 1'b1;
            default:  s_axis_tready = 1'b0;
        endcase
    end

    assign accept_c    = s_axis_tvalid && s_axis_tready;
    assign last_beat_c = (beat_cnt == BEAT_WIDTH'(WORDS_PER_IMAGE - 1));
    assign wr_addr_c   = ADDR_WIDTH'(32'(slot) * WORDS_PER_IMAGE + 32'(beat_cnt));
    assign next_slot_c = (slot == SLOT_WIDTH'(N_SLOTS - 1)) ? '0 : slot + SLOT_WIDTH'(1);

    // Frame FSM, write stage and status reporting.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            slot         <= '0;
            mem_wr_valid <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            frame_done   <= 1'b0;
            frame_slot   <= '0;
            frame_count  <= '0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (mem_wr_valid && mem_wr_ready) begin
                mem_wr_valid <= 1'b0;
            end
            // Clear first so an error raised in the same cycle wins.
            if (err_clear) begin
                err_short <= 1'b0;
                err_long  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (accept_c) begin
                        mem_wr_valid <= 1'b1;
                        mem_wr_addr  <= wr_addr_c;
                        mem_wr_data  <= s_axis_tdata;
                        if (last_beat_c && s_axis_tlast) begin
                            frame_done  <= 1'b1;
                            frame_slot  <= slot;
                            frame_count <= frame_count + 32'd1;
                            slot        <= next_slot_c;
                            beat_cnt    <= '0;
                            if (!enable) begin
                                state <= ST_IDLE;
                            end
                        end else if (last_beat_c) begin
                            err_long <= 1'b1;
                            state    <= ST_DRAIN;
                        end else if (s_axis_tlast) begin
                            // Short frame: the slot is reused by the next frame.
                            err_short <= 1'b1;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_c && s_axis_tlast) begin
                        beat_cnt <= '0;
                        state    <= enable ? ST_RECV : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef LRF_SINK_CHECKSUM_EN
    logic [31:0] beat_sum_c;
    logic [31:0] csum_acc;

    always_comb begin
        beat_sum_c = '0;
        for (int unsigned i = 0; i < PIXELS_PER_BEAT; i++) begin
            beat_sum_c = beat_sum_c + 32'(s_axis_tdata[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
    end

    // Running pixel sum of the frame; published with frame_done, discarded on framing errors.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            csum_acc       <= '0;
            frame_checksum <= '0;
        end else if (state == ST_RECV && accept_c) begin
            if (last_beat_c && s_axis_tlast) begin
                frame_checksum <= csum_acc + beat_sum_c;
                csum_acc       <= '0;
            end else if (last_beat_c || s_axis_tlast) begin
                csum_acc <= '0;
            end else begin
                csum_acc <= csum_acc + beat_sum_c;
            end
        end
    end
`else
    assign frame_checksum = 32'd0;
`endif

endmodule

// File: tb/tb_lrf_frame_sink.sv
// Randomized self-checking bench for lrf_frame_sink against a frame-level reference model (4 words/frame, 2 slots).
module tb_lrf_frame_sink;

    localparam int unsigned PPB = 16;
    localparam int unsigned PW  = 8;
    localparam int unsigned DIM = 8;
    localparam int unsigned NS  = 2;
    localparam int unsigned WW  = PPB * PW;
    localparam int unsigned WPI = DIM * DIM / PPB;
    localparam int unsigned AW  = 3;

`ifdef LRF_SINK_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic          mem_wr_valid;
    logic          mem_wr_ready = 1'b1;
    logic [AW-1:0] mem_wr_addr;
    logic [WW-1:0] mem_wr_data;
    logic          enable = 1'b0;
    logic          err_clear = 1'b0;
    logic          frame_done;
    logic [0:0]    frame_slot;
    logic [31:0]   frame_count;
    logic          err_short;
    logic          err_long;
    logic [31:0]   frame_checksum;

    lrf_frame_sink #(
        .PIXELS_PER_BEAT(PPB),
        .PIXEL_WIDTH    (PW),
        .IMAGE_DIM      (DIM),
        .N_SLOTS        (NS)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .mem_wr_valid  (mem_wr_valid),
        .mem_wr_ready  (mem_wr_ready),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data),
        .enable        (enable),
        .err_clear     (err_clear),
        .frame_done    (frame_done),
        .frame_slot    (frame_slot),
        .frame_count   (frame_count),
        .err_short     (err_short),
        .err_long      (err_long),
        .frame_checksum(frame_checksum)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: where the stream is within a frame, which slot it targets, what the world should see.
    typedef enum int {M_IDLE, M_RECV, M_DRAIN} mode_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    mode_t       m_mode;
    int          m_pos;
    int          m_slot;
    bit          m_pending;
    bit          m_done;
    int          m_done_slot;
    int unsigned m_count;
    bit          m_short;
    bit          m_long;
    int unsigned m_sum;
    int unsigned m_csum;
    wr_t         exp_q[$];
    bit          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] prev_data;

    int ready_mode = 0;
    bit gap_en     = 1'b0;
    bit rand_clear = 1'b0;

    function automatic int unsigned pix_sum(input logic [WW-1:0] d);
        int unsigned s = 0;
        for (int k = 0; k < PPB; k++) s += 32'(d[k*PW +: PW]);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pos = 0; m_slot = 0; m_pending = 1'b0; m_done = 1'b0;
        m_done_slot = 0; m_count = 0; m_short = 1'b0; m_long = 1'b0; m_sum = 0; m_csum = 0;
        exp_q.delete();
        prev_stall = 1'b0;
    endtask

    task automatic check_outputs();
        bit  exp_ready;
        wr_t w;
        exp_ready = (m_mode == M_DRAIN) || (m_mode == M_RECV && (!m_pending || mem_wr_ready));
        check_eq("tready", 128'(s_axis_tready), 128'(exp_ready));
        check_eq("wr_valid", 128'(mem_wr_valid), 128'(m_pending));
        check_eq("frame_done", 128'(frame_done), 128'(m_done));
        check_eq("frame_slot", 128'(frame_slot), 128'(m_done_slot));
        check_eq("frame_count", 128'(frame_count), 128'(m_count));
        check_eq("err_short", 128'(err_short), 128'(m_short));
        check_eq("err_long", 128'(err_long), 128'(m_long));
        check_eq("checksum", 128'(frame_checksum), 128'(m_csum));
        if (prev_stall) begin
            check_eq("stall_addr_hold", 128'(mem_wr_addr), 128'(prev_addr));
            check_eq("stall_data_hold", 128'(mem_wr_data), 128'(prev_data));
        end
        if (mem_wr_valid && mem_wr_ready) begin
            check_eq("wr_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_eq("wr_addr", 128'(mem_wr_addr), 128'(w.addr));
                check_eq("wr_data", 128'(mem_wr_data), 128'(w.data));
            end
        end
        prev_stall = mem_wr_valid && !mem_wr_ready;
        prev_addr  = mem_wr_addr;
        prev_data  = mem_wr_data;
    endtask

    task automatic model_step(input bit acc);
        wr_t         w;
        int unsigned s;
        m_done = 1'b0;
        if (m_pending && mem_wr_ready) m_pending = 1'b0;
        if (err_clear) begin
            m_short = 1'b0;
            m_long  = 1'b0;
        end
        case (m_mode)
            M_IDLE: if (enable) m_mode = M_RECV;
            M_RECV: if (acc) begin
                w.addr = AW'(m_slot * WPI + m_pos);
                w.data = s_axis_tdata;
                exp_q.push_back(w);
                m_pending = 1'b1;
                s = pix_sum(s_axis_tdata);
                if (m_pos == WPI - 1 && s_axis_tlast) begin
                    m_done = 1'b1; m_done_slot = m_slot; m_count++;
                    if (CSUM_EN) m_csum = m_sum + s;
                    m_sum = 0; m_slot = (m_slot + 1) % NS; m_pos = 0;
                    if (!enable) m_mode = M_IDLE;
                end else if (m_pos == WPI - 1) begin
                    m_long = 1'b1; m_sum = 0; m_mode = M_DRAIN;
                end else if (s_axis_tlast) begin
                    m_short = 1'b1; m_sum = 0; m_pos = 0;
                end else begin
                    m_pos++; m_sum += s;
                end
            end
            M_DRAIN: if (acc && s_axis_tlast) begin
                m_pos  = 0;
                m_mode = enable ? M_RECV : M_IDLE;
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = s_axis_tvalid && s_axis_tready;
        check_outputs();
        model_step(acc);
        @(posedge clk);
        #1;
        case (ready_mode)
            1:       mem_wr_ready = ~mem_wr_ready;
            2:       mem_wr_ready = 1'($urandom_range(0, 1));
            3:       mem_wr_ready = 1'b0;
            default: mem_wr_ready = 1'b1;
        endcase
        err_clear = rand_clear && ($urandom_range(0, 15) == 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    function automatic logic [WW-1:0] make_data(input int pat);
        logic [WW-1:0] d;
        case (pat)
            1:       d = {PPB{8'h01}};
            2:       d = {PPB{8'hFF}};
            default: d = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return d;
    endfunction

    // Offer n beats, tlast on beat last_idx; enable drops when beat drop_at is offered.
    task automatic send_beats(input int n, input int last_idx, input int pat, input int drop_at);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < n) begin
            if (!s_axis_tvalid && !(gap_en && $urandom_range(0, 3) == 0)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = make_data(pat);
                s_axis_tlast  = (i == last_idx);
                if (i == drop_at) enable = 1'b0;
            end
            tick(acc);
            if (acc) begin
                i++;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end
            budget++;
            if (budget > 200) begin
                check_eq("send_timeout", 128'(i), 128'(n));
                s_axis_tvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        err_clear     = 1'b0;
        rst_n         = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int n;
        int last;
        int drop;

        reset_dut();
        check_eq("rst_tready", 128'(s_axis_tready), 128'(0));
        check_eq("rst_wr_valid", 128'(mem_wr_valid), 128'(0));
        check_eq("rst_wr_addr", 128'(mem_wr_addr), 128'(0));
        check_eq("rst_wr_data", 128'(mem_wr_data), 128'(0));
        check_eq("rst_done", 128'(frame_done), 128'(0));
        check_eq("rst_count", 128'(frame_count), 128'(0));
        check_eq("rst_flags", 128'({err_short, err_long}), 128'(0));
        check_eq("rst_checksum", 128'(frame_checksum), 128'(0));

        // Three clean frames, memory always ready.
        enable = 1'b1;
        repeat (3) send_beats(4, 3, 0, -1);
        idle(3);
        check_eq("three_frames_count", 128'(frame_count), 128'(3));
        check_eq("three_frames_slot", 128'(frame_slot), 128'(0));

        // Memory backpressure: alternating, then random ready.
        ready_mode = 1;
        repeat (2) send_beats(4, 3, 0, -1);
        ready_mode = 2;
        repeat (2) send_beats(4, 3, 0, -1);
        ready_mode = 0;
        idle(3);

        // Short frame followed by a good frame.
        reset_dut();
        send_beats(2, 1, 0, -1);
        send_beats(4, 3, 0, -1);
        idle(2);
        check_eq("short_flag", 128'(err_short), 128'(1));
        check_eq("short_then_good_slot", 128'(frame_slot), 128'(0));
        check_eq("short_then_good_count", 128'(frame_count), 128'(1));

        // Long frame: 6 beats, tlast on beat 5, then a good frame.
        reset_dut();
        send_beats(6, 5, 0, -1);
        send_beats(4, 3, 0, -1);
        idle(2);
        check_eq("long_flag", 128'(err_long), 128'(1));
        check_eq("long_then_good_count", 128'(frame_count), 128'(1));

        // Enable dropped mid-frame, then flags cleared.
        send_beats(4, 3, 0, 2);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = make_data(0);
        idle(4);
        check_eq("disabled_tready", 128'(s_axis_tready), 128'(0));
        s_axis_tvalid = 1'b0;
        err_clear = 1'b1;
        idle(2);
        check_eq("cleared_flags", 128'({err_short, err_long}), 128'(0));
        enable = 1'b1;

        // Checksum of constant-pixel frames.
        send_beats(4, 3, 1, -1);
        idle(2);
        check_eq("checksum_ones", 128'(frame_checksum), CSUM_EN ? 128'(64) : 128'(0));
        send_beats(4, 3, 2, -1);
        idle(2);
        check_eq("checksum_ff", 128'(frame_checksum), CSUM_EN ? 128'(16320) : 128'(0));

        // Reset while a write is pending.
        ready_mode = 3;
        mem_wr_ready = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = make_data(0);
        tick(acc);
        s_axis_tvalid = 1'b0;
        tick(acc);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_wr_valid", 128'(mem_wr_valid), 128'(0));
        check_eq("midreset_wr_addr", 128'(mem_wr_addr), 128'(0));
        reset_dut();
        ready_mode = 0;
        mem_wr_ready = 1'b1;

        // Random traffic: lengths, tlast positions, gaps, backpressure, clears, enable drops.
        ready_mode = 2;
        gap_en     = 1'b1;
        rand_clear = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n    = $urandom_range(1, 6);
            last = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : n - 1;
            drop = -1;
            if (n == 4 && last == 3 && m_mode == M_RECV && m_pos == 0 && $urandom_range(0, 2) == 0)
                drop = $urandom_range(0, 3);
            send_beats(n, last, 0, drop);
            enable = 1'b1;
        end
        ready_mode = 0;
        gap_en     = 1'b0;
        rand_clear = 1'b0;
        idle(5);
        check_eq("writes_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lrf_frame_sink.md
# lrf_frame_sink

AXI-Stream frame receiver that terminates the LRF output stream (`m_axis_*` of LRF) and writes each fused frame into a ring of frame slots in external buffer memory. It is the receive-side counterpart of the frame source that feeds LRF's interleaved new/old frames. It enforces frame length against `tlast`, recovers from framing errors, and reports completed frames to the control plane.

## Interface
- `PIXELS_PER_BEAT`, 16, pixels per stream beat
- `PIXEL_WIDTH`, 8, bits per pixel; `WORD_WIDTH = PIXELS_PER_BEAT*PIXEL_WIDTH`
- `IMAGE_DIM`, 512, square frame edge; `WORDS_PER_IMAGE = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT`
- `N_SLOTS`, 4, frame slots in the ring (≥1)
- `ADDR_WIDTH`, `$clog2(N_SLOTS*WORDS_PER_IMAGE)`, memory word address width

Ports:
- `s_axis_aclk`  in  1  clock
- `s_axis_aresetn`  in  1  reset; one clock; reset is asynchronous and active-low
- `s_axis_tdata`  in  WORD_WIDTH  pixel beat from LRF
- `s_axis_tvalid`  in  1  beat valid
- `s_axis_tready`  out  1  beat accepted when high with tvalid
- `s_axis_tlast`  in  1  last beat of frame
- `mem_wr_valid`  out  1  write request
- `mem_wr_ready`  in  1  memory accepts write
- `mem_wr_addr`  out  ADDR_WIDTH  word address
- `mem_wr_data`  out  WORD_WIDTH  word data
- `enable`  in  1  start/continue receiving
- `err_clear`  in  1  clears sticky error flags
- `frame_done`  out  1  one-cycle pulse per completed frame
- `frame_slot`  out  $clog2(N_SLOTS) (min 1)  slot of last completed frame
- `frame_count`  out  32  completed frames since reset (wraps)
- `err_short`  out  1  sticky: tlast before beat WORDS_PER_IMAGE-1
- `err_long`  out  1  sticky: no tlast on beat WORDS_PER_IMAGE-1
- `frame_checksum`  out  32  see Configuration

## Operation
- States: IDLE, RECV, DRAIN. Reset → IDLE.
- IDLE: `s_axis_tready`=0. `enable`=1 → RECV next cycle.
- RECV: accept beats; accepted beat written to `slot*WORDS_PER_IMAGE + beat_cnt`; `beat_cnt` increments.
  - Beat `WORDS_PER_IMAGE-1` with tlast: `frame_done` pulse, `frame_slot`←slot, `frame_count`+1, slot←(slot+1) mod N_SLOTS, `beat_cnt`←0; if `enable`=0 → IDLE.
  - tlast on earlier beat: beat is written, `err_short`←1, `beat_cnt`←0, slot unchanged (partial slot overwritten), no `frame_done`.
  - Beat `WORDS_PER_IMAGE-1` without tlast: beat written, `err_long`←1, → DRAIN, slot unchanged, no `frame_done`.
- DRAIN: `s_axis_tready`=1 (independent of memory), beats discarded, no writes; on accepted tlast → `beat_cnt`←0, RECV (or IDLE if `enable`=0).
- `enable` deassertion is honoured only at frame boundaries; mid-frame it is ignored.
- `err_clear` clears both sticky flags; a same-cycle error set takes priority.

## Timing
- Reset values: `s_axis_tready`=0, `mem_wr_valid`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `frame_done`=0, `frame_slot`=0, `frame_count`=0, `err_short`=0, `err_long`=0, `frame_checksum`=0.
- One registered write stage: beat accepted in cycle N → `mem_wr_valid`/addr/data registered in cycle N+1.
- RECV: `s_axis_tready = !mem_wr_valid || mem_wr_ready`; back-to-back beats sustain 1 beat/cycle with `mem_wr_ready`=1.
- `mem_wr_valid`, addr and data hold stable until `mem_wr_ready`.
- `frame_done`, `frame_slot`, `frame_count`, and flags update in cycle N+1 of the accepting beat, with its write.
- Reset mid-frame: all state cleared immediately; the pending write is dropped.

## Configuration
- `LRF_SINK_CHECKSUM_EN` defined: 32-bit unsigned wrapping sum of every pixel of every written beat of the current frame. It is loaded into `frame_checksum` with the `frame_done` pulse. The accumulator resets on `frame_done`, early tlast, and DRAIN entry.
- Undefined: no accumulator logic; `frame_checksum` is constant 0.

## Test plan
Bench setting: `IMAGE_DIM`=8, `PIXELS_PER_BEAT`=16, giving `WORDS_PER_IMAGE`=4; `N_SLOTS`=2.
- 3 frames of 4 beats, tlast on beat 3, `mem_wr_ready`=1 → writes to addr 0–3, 4–7, 0–3; 3 `frame_done` pulses; `frame_slot` 0,1,0; `frame_count`=3.
- `mem_wr_ready` toggling 1010… mid-frame → no beat lost or duplicated; addr/data held while stalled; tready low only when write is pending and not ready.
- tlast on beat 1 → `err_short`=1, no `frame_done`; next good frame written at addr 0–3, `frame_slot`=0.
- 6 beats with tlast on beat 5 → beat 3 written at addr 3, `err_long`=1; beats 4–5 discarded; next frame restarts at addr 0.
- `enable` dropped at beat 2 → frame completes, then `s_axis_tready`=0; `err_clear` with no same-cycle error clears both flags.
- With `LRF_SINK_CHECKSUM_EN`, all pixels=0x01 → `frame_checksum`=64; with all pixels=0xFF → 16320.
